hazard_forward_ctrl: RTL and testbench

- Parametrised successor to the pipeline forwarding logic. It combines EX-stage operand forwarding with load-use hazard detection and data-memory wait stalls.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the ALU operand muxes, the PC/IF-ID hold enables, the ID/EX bubble insert and a global pipeline freeze.
- Keeps a saturating stall-cycle counter for performance visibility.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_forward_ctrl_if.sv | 38 +++
 rtl/hazard_forward_ctrl_fwd_select.sv | 30 +++
 rtl/hazard_forward_ctrl.sv | 96 +++++++++
 tb/tb_hazard_forward_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: ALU operand mux
// selects and the load-use stall FSM state.
package hazard_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    HZ_IDLE     = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for hazard_forward_ctrl: stage register fields in,
// forwarding selects, stall controls, statistics and FSM debug view out.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] id_rs, id_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic              id_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite;
  // Memory handshake: an access is in flight while exmem_memaccess is high and
  // completes on the first cycle dmem_ready is also high; until then the
  // whole pipeline is frozen.
  logic              exmem_memaccess, dmem_ready;

  logic [1:0]        forward_a, forward_b;
  logic              pc_hold, ifid_hold, idex_bubble, pipe_freeze;
  logic [CNT_W-1:0]  stall_cnt;
  hz_state_e         dbg_state;
  logic [2:0]        dbg_lu_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_rs, idex_rt, idex_rd, idex_memread,
           exmem_regwrite, exmem_rd, exmem_memaccess, dmem_ready,
           memwb_regwrite, memwb_rd,
    input  forward_a, forward_b, pc_hold, ifid_hold, idex_bubble, pipe_freeze,
           stall_cnt, dbg_state, dbg_lu_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_rs, idex_rt, idex_rd, idex_memread,
           exmem_regwrite, exmem_rd, exmem_memaccess, dmem_ready,
           memwb_regwrite, memwb_rd,
    output forward_a, forward_b, pc_hold, ifid_hold, idex_bubble, pipe_freeze,
           stall_cnt, dbg_state, dbg_lu_cnt
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Per-operand forwarding select: EX/MEM result wins over MEM/WB, otherwise
// the register file value is used.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  output logic [1:0]        sel_o
);

  logic ex_match, wb_match;

  assign ex_match = exmem_regwrite_i && (exmem_rd_i == src_i) &&
                    (!ZERO_REG_EN || (exmem_rd_i != '0));
  assign wb_match = memwb_regwrite_i && (memwb_rd_i == src_i) &&
                    (!ZERO_REG_EN || (memwb_rd_i != '0));

  always_comb begin
    sel_o = FWD_REG;
    if (ex_match)      sel_o = FWD_EXMEM;
    else if (wb_match) sel_o = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding, load-use bubble insertion and data-memory wait freeze
// for a five-stage pipeline, with a saturating stalled-cycle counter.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LU_STALL_CYCLES = 1,
  parameter bit ZERO_REG_EN     = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_ctrl_if.slave  hz
);

  localparam bit       MULTI_STALL = (LU_STALL_CYCLES > 1);
  localparam logic [2:0] LU_RELOAD = MULTI_STALL ? 3'(LU_STALL_CYCLES - 2) : 3'd0;

  hz_state_e        state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu_hit, mw_hit, stall_req;
  logic             hold, bubble, freeze;
  logic [1:0]       fwd_a, fwd_b;

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_a (
    .src_i(hz.idex_rs), .exmem_regwrite_i(hz.exmem_regwrite), .exmem_rd_i(hz.exmem_rd),
    .memwb_regwrite_i(hz.memwb_regwrite), .memwb_rd_i(hz.memwb_rd), .sel_o(fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_b (
    .src_i(hz.idex_rt), .exmem_regwrite_i(hz.exmem_regwrite), .exmem_rd_i(hz.exmem_rd),
    .memwb_regwrite_i(hz.memwb_regwrite), .memwb_rd_i(hz.memwb_rd), .sel_o(fwd_b)
  );

  assign lu_hit = hz.idex_memread && (!ZERO_REG_EN || (hz.idex_rd != '0)) &&
                  ((hz.idex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.idex_rd == hz.id_rt)));
  assign mw_hit = hz.exmem_memaccess && !hz.dmem_ready;

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    stall_req = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (lu_hit) begin
          stall_req = 1'b1;
          if (MULTI_STALL) begin
            state_d  = HZ_LU_STALL;
            lu_cnt_d = LU_RELOAD;
          end
        end
      end
      HZ_LU_STALL: begin
        stall_req = 1'b1;
        if (lu_cnt_q == 3'd0) state_d  = HZ_IDLE;
        else                  lu_cnt_d = lu_cnt_q - 3'd1;
      end
      default: state_d = HZ_IDLE;
    endcase
    // A memory wait freezes everything, so a pending load-use stall resumes intact.
    if (mw_hit) begin
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
    end
  end

  assign hold   = rst_n && (stall_req || mw_hit);
  assign bubble = rst_n && stall_req && !mw_hit;
  assign freeze = rst_n && mw_hit;

  assign stall_cnt_d = (hold && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_IDLE;
      lu_cnt_q    <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.forward_a   = fwd_a;
  assign hz.forward_b   = fwd_b;
  assign hz.pc_hold     = hold;
  assign hz.ifid_hold   = hold;
  assign hz.idex_bubble = bubble;
  assign hz.pipe_freeze = freeze;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.dbg_state   = state_q;
  assign hz.dbg_lu_cnt  = lu_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Drives two controller configurations from one stimulus stream and compares
// both against a remaining-bubbles reference model every cycle.
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam int REG_AW = 5;
  localparam int LU_A = 3, LU_B = 1;
  localparam bit Z_A = 1'b1, Z_B = 1'b0;
  localparam int CW_A = 4, CW_B = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs, id_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic id_uses_rt, idex_memread, exmem_regwrite, exmem_memaccess, dmem_ready, memwb_regwrite;

  hazard_forward_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CW_A)) ifa ();
  hazard_forward_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CW_B)) ifb ();

  assign ifa.id_rs = id_rs;                     assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;                     assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rt = id_uses_rt;           assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.idex_rs = idex_rs;                 assign ifb.idex_rs = idex_rs;
  assign ifa.idex_rt = idex_rt;                 assign ifb.idex_rt = idex_rt;
  assign ifa.idex_rd = idex_rd;                 assign ifb.idex_rd = idex_rd;
  assign ifa.idex_memread = idex_memread;       assign ifb.idex_memread = idex_memread;
  assign ifa.exmem_regwrite = exmem_regwrite;   assign ifb.exmem_regwrite = exmem_regwrite;
  assign ifa.exmem_rd = exmem_rd;               assign ifb.exmem_rd = exmem_rd;
  assign ifa.exmem_memaccess = exmem_memaccess; assign ifb.exmem_memaccess = exmem_memaccess;
  assign ifa.dmem_ready = dmem_ready;           assign ifb.dmem_ready = dmem_ready;
  assign ifa.memwb_regwrite = memwb_regwrite;   assign ifb.memwb_regwrite = memwb_regwrite;
  assign ifa.memwb_rd = memwb_rd;               assign ifb.memwb_rd = memwb_rd;

  hazard_forward_ctrl #(.REG_AW(REG_AW), .LU_STALL_CYCLES(LU_A), .ZERO_REG_EN(Z_A), .CNT_W(CW_A))
    dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
  hazard_forward_ctrl #(.REG_AW(REG_AW), .LU_STALL_CYCLES(LU_B), .ZERO_REG_EN(Z_B), .CNT_W(CW_B))
    dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));

  int tests_run = 0;
  int tests_failed = 0;
  int left[2];
  longint cnt[2];
  int bub_seen[2];
  int frz_seen[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] src, input bit z);
    if (exmem_regwrite && exmem_rd == src && (exmem_rd != 0 || !z)) return 2'b10;
    if (memwb_regwrite && memwb_rd == src && (memwb_rd != 0 || !z)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu(input bit z);
    return idex_memread && (idex_rd != 0 || !z) &&
           (idex_rd == id_rs || (id_uses_rt && idex_rd == id_rt));
  endfunction

  // Compare both DUTs against the model, then advance the model to the next edge.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] fa, fb;
      logic ph, ih, bb, pf, st;
      logic [63:0] sc;
      logic [2:0] lc;
      bit z, mw, lu, stl, e_hold, e_bub, e_frz;
      int lu_n, cw;
      string nm;
      if (i == 0) begin
        fa = ifa.forward_a; fb = ifa.forward_b; ph = ifa.pc_hold; ih = ifa.ifid_hold;
        bb = ifa.idex_bubble; pf = ifa.pipe_freeze; sc = 64'(ifa.stall_cnt);
        st = ifa.dbg_state; lc = ifa.dbg_lu_cnt; z = Z_A; lu_n = LU_A; cw = CW_A; nm = "A";
      end else begin
        fa = ifb.forward_a; fb = ifb.forward_b; ph = ifb.pc_hold; ih = ifb.ifid_hold;
        bb = ifb.idex_bubble; pf = ifb.pipe_freeze; sc = 64'(ifb.stall_cnt);
        st = ifb.dbg_state; lc = ifb.dbg_lu_cnt; z = Z_B; lu_n = LU_B; cw = CW_B; nm = "B";
      end
      if (!rst_n) begin
        left[i] = 0;
        cnt[i]  = 0;
      end
      mw  = exmem_memaccess && !dmem_ready;
      lu  = m_lu(z);
      stl = left[i] > 0;
      e_hold = rst_n && (mw || stl || lu);
      e_bub  = rst_n && !mw && (stl || lu);
      e_frz  = rst_n && mw;
      check($sformatf("%s.fwd_a", nm), 64'(fa), 64'(m_fwd(idex_rs, z)));
      check($sformatf("%s.fwd_b", nm), 64'(fb), 64'(m_fwd(idex_rt, z)));
      check($sformatf("%s.pc_hold", nm), 64'(ph), 64'(e_hold));
      check($sformatf("%s.ifid_hold", nm), 64'(ih), 64'(e_hold));
      check($sformatf("%s.bubble", nm), 64'(bb), 64'(e_bub));
      check($sformatf("%s.freeze", nm), 64'(pf), 64'(e_frz));
      check($sformatf("%s.stall_cnt", nm), sc, 64'(cnt[i]));
      check($sformatf("%s.state", nm), 64'(st), 64'(stl));
      check($sformatf("%s.lu_cnt", nm), 64'(lc), stl ? 64'(left[i] - 1) : 64'd0);
      if (bb === 1'b1) bub_seen[i]++;
      if (pf === 1'b1) frz_seen[i]++;
      if (rst_n) begin
        if (mw) ;
        else if (stl) left[i]--;
        else if (lu) left[i] = lu_n - 1;
        if (e_hold && cnt[i] < ((64'sd1 <<< cw) - 1)) cnt[i]++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; idex_rs = '0; idex_rt = '0; idex_rd = '0;
    exmem_rd = '0; memwb_rd = '0; id_uses_rt = 1'b0; idex_memread = 1'b0;
    exmem_regwrite = 1'b0; exmem_memaccess = 1'b0; dmem_ready = 1'b1; memwb_regwrite = 1'b0;
  endtask

  task automatic load_use();
    idex_memread = 1'b1; idex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd1;
  endtask

  task automatic clear_seen();
    bub_seen = '{0, 0};
    frz_seen = '{0, 0};
  endtask

  initial begin
    left = '{0, 0};
    cnt  = '{0, 0};
    clear_seen();
    clear_inputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // EX/MEM beats MEM/WB, then MEM/WB alone
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; memwb_regwrite = 1'b1; memwb_rd = 5'd3;
    idex_rs = 5'd3; idex_rt = 5'd3;
    step();
    check("prio_a_exmem", 64'(ifa.forward_a), 64'(2'b10));
    check("prio_b_exmem", 64'(ifb.forward_b), 64'(2'b10));
    exmem_regwrite = 1'b0;
    step();
    check("prio_a_memwb", 64'(ifa.forward_a), 64'(2'b01));

    // Register 0: hardwired in A, ordinary in B
    clear_inputs();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; idex_rs = 5'd0;
    step();
    check("zero_a_hardwired", 64'(ifa.forward_a), 64'(2'b00));
    check("zero_b_forwarded", 64'(ifb.forward_a), 64'(2'b10));

    // Load-use via rt: the bubble clears idex_memread after the first cycle
    clear_inputs();
    clear_seen();
    load_use();
    step();
    idex_memread = 1'b0;
    repeat (5) step();
    check("lu_len_a", 64'(bub_seen[0]), 64'(LU_A));
    check("lu_len_b", 64'(bub_seen[1]), 64'(LU_B));

    clear_inputs();
    clear_seen();
    load_use();
    id_uses_rt = 1'b0;
    repeat (3) step();
    check("lu_no_rt_a", 64'(bub_seen[0]), 64'd0);
    check("lu_no_rt_b", 64'(bub_seen[1]), 64'd0);

    // Memory wait arriving on the second stall cycle
    clear_inputs();
    load_use();
    step();
    idex_memread = 1'b0;
    clear_seen();
    exmem_memaccess = 1'b1; dmem_ready = 1'b0;
    repeat (4) step();
    check("mw_freeze_a", 64'(frz_seen[0]), 64'd4);
    check("mw_no_bubble_a", 64'(bub_seen[0]), 64'd0);
    dmem_ready = 1'b1;
    clear_seen();
    repeat (4) step();
    check("mw_resume_a", 64'(bub_seen[0]), 64'd2);
    check("mw_resume_b", 64'(bub_seen[1]), 64'd0);

    // Asynchronous reset in the middle of a stall
    clear_inputs();
    load_use();
    step();
    idex_memread = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_pc_hold", 64'(ifa.pc_hold), 64'd0);
    check("rst_bubble", 64'(ifa.idex_bubble), 64'd0);
    check("rst_stall_cnt", 64'(ifa.stall_cnt), 64'd0);
    check("rst_state", 64'(ifa.dbg_state), 64'(HZ_IDLE));
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 64'(ifa.dbg_state), 64'(HZ_IDLE));

    // Counter saturation on the 4-bit instance
    clear_inputs();
    exmem_memaccess = 1'b1; dmem_ready = 1'b0;
    repeat (20) step();
    check("sat_cnt_a", 64'(ifa.stall_cnt), 64'd15);

    // Randomized traffic with a narrow register range to provoke hits
    for (int n = 0; n < 400; n++) begin
      id_rs = 5'($urandom_range(0, 3));       id_rt = 5'($urandom_range(0, 3));
      idex_rs = 5'($urandom_range(0, 3));     idex_rt = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3));     exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));    id_uses_rt = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) == 0);
      exmem_regwrite = 1'($urandom_range(0, 1));
      memwb_regwrite = 1'($urandom_range(0, 1));
      exmem_memaccess = 1'($urandom_range(0, 1));
      dmem_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
